// File: rtl/ifu_pkg.sv
// ifu_pkg -- shared types for the instruction-fetch unit.
//   PC_RESET_DEFAULT : default reset fetch address / IM base address.
//   fetch_entry_t    : one fetched word as it travels toward decode.
//   fetch_state_t    : fetch engine state (RUN fetches, HALT waits for a redirect).
package ifu_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
   } fetch_entry_t;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/ifu_fetch_queue_fifo.sv
// fetch_fifo -- synchronous FIFO of fetch_entry_t, DEPTH entries (power of two).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push, din       : write din at the tail; accepted when not full, or when
//                     full together with pop
//   pop             : drop the head entry (ignored when empty)
//   flush           : empty the FIFO; overrides push and pop
//   full, empty     : occupancy flags
//   head            : entry at the read pointer (registered storage, no bypass)
module fetch_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  fetch_entry_t din,
   input  logic         pop,
   input  logic         flush,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO can still take a write when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only observed after it was written.
   always_ff @(posedge clk) begin
      if (!reset && !flush && do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue -- instruction fetch unit: fetch PC, instruction ROM and a
// small queue in front of decode.
// Parameters:
//   PC_RESET  : reset fetch address and ROM base address
//   IM_WORDS  : ROM depth in words (power of two)
//   QDEPTH    : queue entries (power of two, >= 2)
//   INIT_FILE : hex image for the ROM; the load flow places it into im before
//               the first clock, words not covered by the image read as 0
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   redirect_valid, redirect_pc : flush the queue and restart fetch at redirect_pc
//   out_ready                   : decode accepts the head entry this cycle
//   out_valid, out_pc,
//   out_instr, out_exc          : head entry; all zero when out_valid=0
// Handshake: the head transfers on a cycle where out_valid && out_ready at the
// rising edge; while out_valid && !out_ready the outputs hold steady.
module ifu_fetch_queue
   import ifu_pkg::*;
#(
   parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
   parameter int          IM_WORDS  = 4096,
   parameter int          QDEPTH    = 4,
   parameter              INIT_FILE = "code.txt"
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_exc
);

   localparam int IW = $clog2(IM_WORDS);

   logic [31:0]  im [IM_WORDS];

   logic [31:0]  fpc;
   fetch_state_t state_q;
   fetch_state_t state_d;

   logic [29:0]  index;
   logic         fault;
   logic         enq;
   logic         deq;
   logic         q_full;
   logic         q_empty;
   fetch_entry_t new_entry;
   fetch_entry_t q_head;

   // Word index relative to the ROM base; the subtraction wraps, so a PC below
   // the base lands far out of range and faults.
   assign index = 30'((fpc - PC_RESET) >> 2);
   assign fault = (fpc[1:0] != 2'b00) || ({2'b00, index} >= 32'(IM_WORDS));

   assign new_entry.pc    = fpc;
   assign new_entry.instr = fault ? 32'h0 : im[index[IW-1:0]];
   assign new_entry.exc   = fault;

   assign out_valid = !q_empty;
   assign deq       = out_valid && out_ready;
   // Redirect wins over fetch; a full queue only takes a word while draining.
   assign enq       = (state_q == RUN) && !redirect_valid && (!q_full || deq);

   fetch_fifo #(
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (enq),
      .din   (new_entry),
      .pop   (deq),
      .flush (redirect_valid),
      .full  (q_full),
      .empty (q_empty),
      .head  (q_head)
   );

   always_comb begin
      out_pc    = 32'h0;
      out_instr = 32'h0;
      out_exc   = 1'b0;
      if (out_valid) begin
         out_pc    = q_head.pc;
         out_instr = q_head.instr;
         out_exc   = q_head.exc;
      end
   end

   // A faulting fetch parks the engine; only a redirect (or reset) restarts it.
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = RUN;
      end else if (enq && fault) begin
         state_d = HALT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         fpc     <= PC_RESET;
      end else begin
         state_q <= state_d;
         if (redirect_valid) begin
            fpc <= redirect_pc;
         end else if (enq && !fault) begin
            fpc <= fpc + 32'd4;
         end
      end
   end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
   } ent_t;

   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] ein;
      logic        eexc;
   } vec_t;

   // ---------------- clock / reset / DUTs ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_ready;
   logic        ov   [2];
   logic [31:0] opc  [2];
   logic [31:0] oin  [2];
   logic        oexc [2];

   always #5 clk = ~clk;

   ifu_fetch_queue #(
      .PC_RESET  (32'h0000_3000),
      .IM_WORDS  (4096),
      .QDEPTH    (4),
      .INIT_FILE ("code.txt")
   ) dut0 (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_ready      (out_ready),
      .out_valid      (ov[0]),
      .out_pc         (opc[0]),
      .out_instr      (oin[0]),
      .out_exc        (oexc[0])
   );

   ifu_fetch_queue #(
      .PC_RESET  (32'h0000_3000),
      .IM_WORDS  (16),
      .QDEPTH    (4),
      .INIT_FILE ("code.txt")
   ) dut1 (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_ready      (out_ready),
      .out_valid      (ov[1]),
      .out_pc         (opc[1]),
      .out_instr      (oin[1]),
      .out_exc        (oexc[1])
   );

   // ---------------- reference model ----------------
   logic [31:0] img [4096];
   ent_t        mq [2][$];
   logic [31:0] m_fpc  [2];
   bit          m_halt [2];
   int unsigned m_words [2] = '{4096, 16};

   int vectors     = 0;
   int miscompares = 0;
   bit model_chk   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behaviour of one rising edge, expressed as queue operations.
   task automatic model_edge(input logic r, input logic rv, input logic [31:0] rpc,
                             input logic rdy);
      ent_t        e;
      logic [31:0] idx;
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            mq[k].delete();
            m_fpc[k]  = 32'h3000;
            m_halt[k] = 1'b0;
         end else begin
            if (mq[k].size() > 0 && rdy) void'(mq[k].pop_front());
            if (rv) begin
               mq[k].delete();
               m_fpc[k]  = rpc;
               m_halt[k] = 1'b0;
            end else if (!m_halt[k] && mq[k].size() < 4) begin
               idx     = (m_fpc[k] - 32'h3000) >> 2;
               e.pc    = m_fpc[k];
               e.exc   = (m_fpc[k] % 4 != 0) || (idx >= m_words[k]);
               e.instr = e.exc ? 32'h0 : img[idx];
               mq[k].push_back(e);
               if (e.exc) m_halt[k] = 1'b1;
               else       m_fpc[k]  = m_fpc[k] + 32'd4;
            end
         end
      end
   endtask

   task automatic model_compare();
      ent_t e;
      logic v;
      for (int k = 0; k < 2; k++) begin
         v = (mq[k].size() > 0);
         if (v) e = mq[k][0];
         else begin
            e.pc = 32'h0; e.instr = 32'h0; e.exc = 1'b0;
         end
         chk($sformatf("dut%0d out_valid", k), {31'h0, ov[k]}, {31'h0, v});
         chk($sformatf("dut%0d out_pc", k), opc[k], e.pc);
         chk($sformatf("dut%0d out_instr", k), oin[k], e.instr);
         chk($sformatf("dut%0d out_exc", k), {31'h0, oexc[k]}, {31'h0, e.exc});
      end
   endtask

   // ---------------- driver tasks ----------------
   logic        cur_r, cur_rv, cur_rdy;
   logic [31:0] cur_rpc;

   task automatic drive_and_sample(input logic r, input logic rv, input logic [31:0] rpc,
                                   input logic rdy);
      reset = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
      cur_r = r; cur_rv = rv; cur_rpc = rpc; cur_rdy = rdy;
      @(negedge clk);
      if (model_chk) model_compare();
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_edge(cur_r, cur_rv, cur_rpc, cur_rdy);
      #1;
   endtask

   task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
      drive_and_sample(r, rv, rpc, rdy);
      finish_cycle();
   endtask

   // ---------------- directed table ----------------
   vec_t tab[$];

   function automatic vec_t mk(input logic rst, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic ev, input logic [31:0] epc,
                               input logic [31:0] ein, input logic eexc);
      vec_t v;
      v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
      v.ev = ev; v.epc = epc; v.ein = ein; v.eexc = eexc;
      return v;
   endfunction

   initial begin
      logic [31:0] rpc;
      logic [31:0] exp_pc;
      int          k;

      // ROM image shared by both instances.
      for (int i = 0; i < 4096; i++)
         img[i] = (i < 64) ? (32'h2400_0000 | 32'(i)) : $urandom;
      img[0] = 32'h2401_0001;
      img[1] = 32'h2402_0002;
      for (int i = 0; i < 4096; i++) dut0.im[i] = img[i];
      for (int i = 0; i < 16; i++)   dut1.im[i] = img[i];

      // Backpressure from reset: 10 stalled cycles, then drain.
      tab.push_back(mk(0,0,0,0, 0,32'h0,32'h0,0));
      tab.push_back(mk(0,0,0,0, 1,32'h3000,32'h2401_0001,0));
      for (int i = 0; i < 8; i++) tab.push_back(mk(0,0,0,0, 1,32'h3000,32'h2401_0001,0));
      tab.push_back(mk(0,0,0,1, 1,32'h3000,32'h2401_0001,0));
      tab.push_back(mk(0,0,0,1, 1,32'h3004,32'h2402_0002,0));
      tab.push_back(mk(0,0,0,1, 1,32'h3008,32'h2400_0002,0));
      tab.push_back(mk(0,0,0,1, 1,32'h300C,32'h2400_0003,0));
      tab.push_back(mk(0,0,0,1, 1,32'h3010,32'h2400_0004,0));
      tab.push_back(mk(0,0,0,1, 1,32'h3014,32'h2400_0005,0));
      // Reset held two cycles with a full queue draining.
      tab.push_back(mk(1,0,0,1, 1,32'h3018,32'h2400_0006,0));
      tab.push_back(mk(1,0,0,1, 0,32'h0,32'h0,0));
      tab.push_back(mk(0,0,0,1, 0,32'h0,32'h0,0));
      tab.push_back(mk(0,0,0,1, 1,32'h3000,32'h2401_0001,0));
      // Reset, fill three entries, redirect to 0x3040.
      tab.push_back(mk(1,0,0,0, 1,32'h3004,32'h2402_0002,0));
      tab.push_back(mk(0,0,0,0, 0,32'h0,32'h0,0));
      tab.push_back(mk(0,0,0,0, 1,32'h3000,32'h2401_0001,0));
      tab.push_back(mk(0,0,0,0, 1,32'h3000,32'h2401_0001,0));
      tab.push_back(mk(0,1,32'h3040,0, 1,32'h3000,32'h2401_0001,0));
      tab.push_back(mk(0,0,0,1, 0,32'h0,32'h0,0));
      tab.push_back(mk(0,0,0,1, 1,32'h3040,32'h2400_0010,0));
      // Misaligned redirect: one faulting entry, then silence until redirect.
      tab.push_back(mk(0,1,32'h3042,1, 1,32'h3044,32'h2400_0011,0));
      tab.push_back(mk(0,0,0,1, 0,32'h0,32'h0,0));
      tab.push_back(mk(0,0,0,0, 1,32'h3042,32'h0,1));
      tab.push_back(mk(0,0,0,1, 1,32'h3042,32'h0,1));
      tab.push_back(mk(0,0,0,1, 0,32'h0,32'h0,0));
      tab.push_back(mk(0,0,0,1, 0,32'h0,32'h0,0));
      tab.push_back(mk(0,1,32'h3000,1, 0,32'h0,32'h0,0));
      tab.push_back(mk(0,0,0,1, 0,32'h0,32'h0,0));
      tab.push_back(mk(0,0,0,1, 1,32'h3000,32'h2401_0001,0));
      tab.push_back(mk(0,0,0,1, 1,32'h3004,32'h2402_0002,0));

      // Initial reset: outputs are unknown before the first reset edge.
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      model_chk = 1'b1;

      foreach (tab[i]) begin
         drive_and_sample(tab[i].rst, tab[i].rv, tab[i].rpc, tab[i].rdy);
         chk($sformatf("tab%0d out_valid", i), {31'h0, ov[0]}, {31'h0, tab[i].ev});
         chk($sformatf("tab%0d out_pc", i), opc[0], tab[i].epc);
         chk($sformatf("tab%0d out_instr", i), oin[0], tab[i].ein);
         chk($sformatf("tab%0d out_exc", i), {31'h0, oexc[0]}, {31'h0, tab[i].eexc});
         finish_cycle();
      end

      // End of memory on the 16-word instance: 0x303C normal, 0x3040 faults, then halt.
      cycle(1, 0, 0, 1);
      for (k = 0; k < 20; k++) begin
         drive_and_sample(0, 0, 0, 1);
         if (k >= 1 && k <= 17) begin
            exp_pc = 32'h3000 + 32'(4 * (k - 1));
            chk($sformatf("eom%0d out_valid", k), {31'h0, ov[1]}, 32'h1);
            chk($sformatf("eom%0d out_pc", k), opc[1], exp_pc);
            chk($sformatf("eom%0d out_instr", k), oin[1], (k == 17) ? 32'h0 : img[k - 1]);
            chk($sformatf("eom%0d out_exc", k), {31'h0, oexc[1]}, (k == 17) ? 32'h1 : 32'h0);
         end else begin
            chk($sformatf("eom%0d out_valid", k), {31'h0, ov[1]}, 32'h0);
         end
         finish_cycle();
      end

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         case ($urandom_range(0, 3))
            0:       rpc = 32'h3000 + 32'(4 * $urandom_range(0, 20));
            1:       rpc = 32'h3000 + 32'($urandom_range(0, 80));
            2:       rpc = 32'h3000 + 32'(4 * $urandom_range(4085, 4100));
            default: rpc = $urandom;
         endcase
         cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), rpc,
               ($urandom_range(0, 9) < 7));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Parametrised instruction-fetch unit for the MIPS pipeline: owns the fetch PC, reads a `$readmemh`-initialised instruction memory, and buffers fetched words in a small queue in front of decode. It replaces the single-register PC/stall scheme with a valid/ready decode handshake, a redirect/flush port for resolved branches and jumps, and a fetch-fault flag for misaligned or out-of-range PCs. It sits between the NPC logic, which issues redirects, and the F/D boundary.

## Interface
- `PC_RESET`, default 32'h0000_3000: reset fetch address and IM base address.
- `IM_WORDS`, default 4096: instruction memory depth in words; must be a power of two.
- `QDEPTH`, default 4: queue entries; must be a power of two, at least 2.
- `INIT_FILE`, default "code.txt": hex image loaded into IM at time 0; unloaded words are 0.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `redirect_valid`  in  1  flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address.
- `out_ready`  in  1  decode can accept the head entry.
- `out_valid`  out  1  head entry present.
- `out_pc`  out  32  PC of the head entry.
- `out_instr`  out  32  instruction word of the head entry.
- `out_exc`  out  1  fetch fault for the head entry.

## Operation
- Internal state:
  - `fpc`: 32-bit fetch PC.
  - Queue: `QDEPTH` entries of {pc, instr, exc}.
  - Read and write pointers of log2(QDEPTH) bits, wrapping modulo QDEPTH.
  - `count`: log2(QDEPTH)+1 bits.
  - FSM state: RUN or HALT.
- Memory index is (fpc − PC_RESET)[31:2]. Subtraction wraps modulo 2^32.
- A fetch faults when either condition holds:
  - fpc[1:0] ≠ 0.
  - The index ≥ IM_WORDS.
- A faulting entry carries exc=1 and instr=0.
- Dequeue happens when out_valid && out_ready.
- Enqueue happens in RUN, when redirect_valid=0, and when (count < QDEPTH or dequeue). Push while full is allowed only together with a pop.
- On enqueue:
  - The entry {fpc, im[index], fault} is written.
  - A non-faulting fetch sets fpc ← fpc+4, wrapping modulo 2^32.
  - A faulting fetch leaves fpc unchanged and moves the FSM RUN→HALT.
- HALT: no enqueues. Dequeues continue normally. The only exit is a redirect or reset.
- Redirect has priority over enqueue. In the redirect cycle:
  - count ← 0 and both pointers ← 0.
  - fpc ← redirect_pc.
  - FSM ← RUN.
  - A head transfer in the same cycle still counts as consumed by decode.
- Delay-slot preservation is the issuer's job. The unit flushes every queued entry unconditionally.
- When out_valid=0, out_pc, out_instr and out_exc are all driven 0.
- count changes by +1 (push only), −1 (pop only) or 0 (both or neither).

## Timing
- Reset (any cycle, including mid-operation, and overriding redirect):
  - fpc=PC_RESET, count=0, pointers=0, FSM=RUN.
  - Every output is 0 in the cycle after reset is sampled high.
- Fetch-to-output latency is 1 cycle. An entry enqueued at edge N is visible at the head from edge N; out_valid rises after that edge. There is no combinational bypass from IM to the outputs.
- First edge with reset low enqueues PC_RESET; out_valid=1 after that edge.
- Redirect sampled at edge N:
  - out_valid=0 after N.
  - The redirect_pc entry is enqueued at N+1 and is visible after N+1.
- Sustained throughput is 1 entry/cycle while out_ready=1, with no gaps after the first.
- Outputs are read combinationally from the queue head register. They are stable while out_valid && !out_ready.

## Structure
- Package `ifu_pkg` holds:
  - The `PC_RESET` default constant.
  - The `fetch_entry_t` struct {pc[31:0], instr[31:0], exc}.
  - The state enum {RUN, HALT}.
- One sub-module, `fetch_fifo`: generic synchronous FIFO of `fetch_entry_t`.
  - Parameter: DEPTH.
  - Ports: push, pop, flush, full, empty, head.
  - Push-when-full is legal only together with pop.
- The top level holds IM, fpc, the FSM and the fault check.

## Test plan
- **Reset start:** IM[0]=0x24010001, IM[1]=0x24020002, out_ready=1. Required:
  - Output pc 0x3000 / 0x24010001 in the first valid cycle.
  - pc 0x3004 / 0x24020002 in the next cycle.
  - out_exc=0.
- **Backpressure:** out_ready=0 for 10 cycles.
  - count saturates at 4 and fpc holds at 0x3010.
  - After release, pcs 0x3000, 0x3004, 0x3008, 0x300C, 0x3010 appear on consecutive cycles, with out_instr stable during the stall.
- **Redirect while not full:** redirect_pc=0x3040 while 3 entries are queued.
  - out_valid=0 for one cycle, then head pc=0x3040.
  - No flushed pc ever appears.
- **Misaligned redirect:** redirect_pc=0x3042. Required:
  - One entry {0x3042, 0, exc=1}.
  - out_valid stays 0 afterwards until redirect_pc=0x3000, then normal fetch resumes.
- **End of memory:** IM_WORDS=16, sequential fetch.
  - pc 0x303C is a normal entry.
  - pc 0x3040 has exc=1, then the unit halts.
- **Reset mid-operation:** full queue, out_ready=1, reset held 2 cycles.
  - All outputs are 0 during reset.
  - Fetch restarts at 0x3000.
